coreriscv_axi4_wrr_lock_scheduler: RTL

CORERISCV_AXI4_WRR_LOCK_SCHEDULER -- requirements
Module: coreriscv_axi4_wrr_lock_scheduler

---
 rtl/coreriscv_axi4_wrr_lock_scheduler_pkg.sv | 14 +
 rtl/coreriscv_axi4_rr_pick.sv | 23 ++
 rtl/coreriscv_axi4_wrr_lock_scheduler.sv | 115 +++++++++++
 3 files changed

// File: rtl/coreriscv_axi4_wrr_lock_scheduler_pkg.sv
// Shared constants and state encoding for the weighted round-robin lock scheduler.
package coreriscv_axi4_wrr_lock_scheduler_pkg;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned BEATS   = 8;
    localparam int unsigned BEAT_W  = 3;
    localparam int unsigned QUOTA_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/coreriscv_axi4_rr_pick.sv
// Round-robin search: first valid requester starting at pointer+1, wrapping back to pointer.
module coreriscv_axi4_rr_pick
    import coreriscv_axi4_wrr_lock_scheduler_pkg::*;
(
    input  logic [3:0] i_valid,
    input  logic [1:0] i_pointer,
    output logic       o_found,
    output logic [1:0] o_index
);

    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int unsigned i = 4; i >= 1; i--) begin
            if (i_valid[i_pointer + 2'(i)]) begin
                o_found = 1'b1;
                o_index = i_pointer + 2'(i);
            end
        end
    end

endmodule

// File: rtl/coreriscv_axi4_wrr_lock_scheduler.sv
// Weighted round-robin grant scheduler that locks onto an owner for multi-beat messages.
module coreriscv_axi4_wrr_lock_scheduler
    import coreriscv_axi4_wrr_lock_scheduler_pkg::*;
#(
    parameter int N_REQ = coreriscv_axi4_wrr_lock_scheduler_pkg::N_REQ,
    parameter int BEATS = coreriscv_axi4_wrr_lock_scheduler_pkg::BEATS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   io_req_valid,
    input  logic [N_REQ-1:0]   io_req_has_data,
    input  logic [QUOTA_W-1:0] io_quota_0,
    input  logic [QUOTA_W-1:0] io_quota_1,
    input  logic [QUOTA_W-1:0] io_quota_2,
    input  logic [QUOTA_W-1:0] io_quota_3,
    input  logic               io_fire,
    output logic [N_REQ-1:0]   io_grant,
    output logic [1:0]         io_chosen,
    output logic               io_locked,
    output logic [BEAT_W-1:0]  io_beat
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t             r_state;
    logic [1:0]         r_owner;
    logic               r_prev_vld;
    logic [QUOTA_W-1:0] r_msg_cnt;
    logic               r_has_data;
    logic [BEAT_W-1:0]  r_beat;
    logic               r_locked;
    logic [N_REQ-1:0]   r_grant;
    logic [1:0]         r_chosen;

    logic               w_found;
    logic [1:0]         w_pick;
    logic [QUOTA_W-1:0] w_quota;
    logic [QUOTA_W-1:0] w_quota_eff;
    logic               w_keep;
    logic [1:0]         w_sel;

    coreriscv_axi4_rr_pick u_pick (
        .i_valid   (io_req_valid),
        .i_pointer (r_owner),
        .o_found   (w_found),
        .o_index   (w_pick)
    );

    always_comb begin
        w_quota = io_quota_0;
        case (r_owner)
            2'd0:    w_quota = io_quota_0;
            2'd1:    w_quota = io_quota_1;
            2'd2:    w_quota = io_quota_2;
            default: w_quota = io_quota_3;
        endcase
    end

    assign w_quota_eff = (w_quota == '0) ? QUOTA_W'(1) : w_quota;
    // r_prev_vld keeps the reset-time pointer from being treated as a real previous owner.
    assign w_keep      = r_prev_vld && io_req_valid[r_owner] && (r_msg_cnt < w_quota_eff);
    assign w_sel       = w_keep ? r_owner : w_pick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_owner    <= 2'd3;
            r_prev_vld <= 1'b0;
            r_msg_cnt  <= '0;
            r_has_data <= 1'b0;
            r_beat     <= '0;
            r_locked   <= 1'b0;
            r_grant    <= '0;
            r_chosen   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= ACTIVE;
                        r_owner    <= w_sel;
                        r_prev_vld <= 1'b1;
                        r_chosen   <= w_sel;
                        r_grant    <= N_REQ'(1) << w_sel;
                        r_has_data <= io_req_has_data[w_sel];
                        if (!w_keep) r_msg_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    if (io_fire) begin
                        if (r_has_data && (r_beat != LAST_BEAT)) begin
                            r_beat   <= r_beat + BEAT_W'(1);
                            r_locked <= 1'b1;
                        end else begin
                            r_beat   <= '0;
                            r_locked <= 1'b0;
                            if (r_msg_cnt != '1) r_msg_cnt <= r_msg_cnt + QUOTA_W'(1);
                            r_state  <= IDLE;
                            r_grant  <= '0;
                        end
                    end else if (!r_locked && !io_req_valid[r_owner]) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_grant  = r_grant;
    assign io_chosen = r_chosen;
    assign io_locked = r_locked;
    assign io_beat   = r_beat;

endmodule
